nec_ir_tx: RTL and testbench
============================

Name: nec_ir_tx

Overview:
NEC-protocol infrared transmitter, the sending end of the IR link that the robot decodes with its IR receiver. It accepts a 32-bit frame over a valid/ready handshake and serialises it as an NEC frame: leader, 32 pulse-distance bits sent LSB first, stop mark, then enforced inter-frame gap. It drives the IR LED driver pin on the controller board and also serves as a bench stimulus source for the robot's receive path.

Parameters:
TICK_CLKS, 28125, clk cycles per NEC unit (562.5 us at 50 MHz)
FRAME_UNITS, 192, minimum frame period in units (108 ms), measured from leader start
CARRIER_CLKS, 1315, clk cycles per carrier period (38 kHz at 50 MHz); used only with NEC_TX_CARRIER_EN

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  synchronous reset, active-low
valid  in  1  frame request
ready  out  1  high only in IDLE; transfer occurs when valid && ready at a clk edge
data  in  32  frame word; bit 0 sent first; layout {~cmd[31:24], cmd[23:16], addr[15:0]}
ir_out  out  1  registered IR drive, high = mark
busy  out  1  high from the cycle after the handshake until done
done  out  1  one-cycle pulse in the last cycle of GAP

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, ready=1, ir_out=0, busy=0, done=0; shift register, unit counter and tick counter cleared. Applies mid-frame: ir_out low from the next edge and no done pulse.
- Handshake: on an edge with valid && ready, latch data and enter LEAD_MARK. ir_out rises in the same edge (first cycle after the handshake). valid while busy is ignored; no queueing.
- Tick counter counts 0..TICK_CLKS-1 and restarts at every state entry. Each wrap advances the unit counter by 1.
- States and durations in units, with ir_out level:
  - IDLE: ir_out=0.
  - LEAD_MARK: 16 units, 1.
  - LEAD_SPACE: 8 units, 0.
  - BIT_MARK: 1 unit, 1.
  - BIT_SPACE: 0.
    - 1 unit if the current bit is 0.
    - 3 units if the current bit is 1.
    - After 32 bits go to STOP_MARK; otherwise shift right and return to BIT_MARK.
  - STOP_MARK: 1 unit, 1.
  - GAP: 0, until a frame-wide unit count (from LEAD_MARK entry) reaches FRAME_UNITS. Assert done on the final cycle, then go to IDLE.
- Frame length before GAP: 24 + 32*2 + 2*popcount(data) + 1 units; maximum 153, which is always < FRAME_UNITS, so GAP is never empty.
- Frame-wide unit counter is 8 bits and saturates; it never wraps.
- All outputs are registered; ready = (state == IDLE).

Optional Feature:
NEC_TX_CARRIER_EN:
- Defined: during mark states, ir_out carries a 38 kHz carrier, high for the first CARRIER_CLKS/3 cycles of each CARRIER_CLKS period. The carrier counter restarts at every mark entry, so each mark begins high. Spaces and IDLE are 0.
- Undefined: ir_out is the raw envelope, for an LED module with its own modulator; CARRIER_CLKS is unused.

Decomposition:
- Package nec_tx_pkg:
  - state enum nec_tx_state_t.
  - constants LEAD_MARK_U=16, LEAD_SPACE_U=8, BIT_MARK_U=1, ZERO_SPACE_U=1, ONE_SPACE_U=3, STOP_MARK_U=1, NUM_BITS=32.
- Sub-module ir_carrier_gen: carrier counter plus duty compare, enabled by a mark signal. Instantiated only under NEC_TX_CARRIER_EN.

Test Plan:
All scenarios run with TICK_CLKS=4 and, for the carrier scenario, CARRIER_CLKS=3.
- Basic frame: data=32'hFD02_6B86, pulse valid 1 cycle.
  - ready drops the next cycle; ir_out high for 64 clks (16 units), then low for 32.
  - 32 bits: 16 ones, each 4 clks high then 12 low; 16 zeros, each 4 high then 4 low. First bit sent is bit 0 (=0).
  - Stop mark 4 clks high; total active 121 units = 484 clks.
  - done pulses at clk 768 after the handshake, then ready=1.
- Decode loopback: feed ir_out envelope into the IR receiver model. Decoded word equals 32'hFD02_6B86 and decoded bits [27:16] equal 12'hD02.
- Busy ignore: assert valid continuously with data changing to 32'h0000_FFFF mid-frame. The transmitted frame is unchanged, and the second frame starts only on the cycle after done.
- Mid-frame reset: rst_n low for 1 cycle during BIT_SPACE of bit 10. On the next edge ir_out=0, busy=0, ready=1, and no done pulse follows.
- Extreme popcount: data=32'hFFFF_FFFF gives 153 active units; data=0 gives 89. Both report done exactly at 192 units.
- NEC_TX_CARRIER_EN defined: within LEAD_MARK, ir_out repeats the pattern 1,0,0 every 3 clks starting high. ir_out is constant 0 in spaces.

Source files
------------

// File: rtl/nec_ir_tx_pkg.sv
// ============================================================================
// Module : nec_tx_pkg
// Brief  : Shared state encoding and NEC timing constants for nec_ir_tx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nec_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4,
        ST_STOP_MARK  = 3'd5,
        ST_GAP        = 3'd6
    } nec_tx_state_t;

    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int BIT_MARK_U   = 1;
    localparam int ZERO_SPACE_U = 1;
    localparam int ONE_SPACE_U  = 3;
    localparam int STOP_MARK_U  = 1;
    localparam int NUM_BITS     = 32;

    function automatic logic is_mark(input logic [2:0] s);
        return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nec_ir_tx_if.sv
// ============================================================================
// Module : nec_ir_tx_if
// Brief  : Frame request handshake and status bundle for nec_ir_tx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface nec_ir_tx_if;
    import nec_tx_pkg::*;

    logic                valid;
    logic                ready;
    logic [NUM_BITS-1:0] data;
    logic                busy;
    logic                done;

    modport master (output valid, output data, input ready, input busy, input done);
    modport slave  (input valid, input data, output ready, output busy, output done);

endinterface

`default_nettype wire

// File: rtl/nec_ir_tx_carrier_gen.sv
// ============================================================================
// Module : ir_carrier_gen
// Brief  : Registered carrier with one-third duty, phase restarted whenever
//          the mark request drops so every mark opens with a high phase.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ir_carrier_gen #(
    parameter int CARRIER_CLKS = 1315
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_mark,
    output logic      o_carrier
);

    localparam int CW = $clog2(CARRIER_CLKS);
    localparam logic [CW-1:0] c_last = CW'(CARRIER_CLKS - 1);
    localparam logic [CW-1:0] c_high = CW'(CARRIER_CLKS / 3);

    logic [CW-1:0] r_cnt;
    logic          r_out;

    // i_mark describes the coming cycle, so r_cnt is the phase about to be shown
    always_ff @(posedge clk) begin
        if (!rst_n || !i_mark) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else begin
            r_out <= (r_cnt < c_high);
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_carrier = r_out;

endmodule

`default_nettype wire

// File: rtl/nec_ir_tx.sv
// ============================================================================
// Module : nec_ir_tx
// Brief  : NEC infrared frame transmitter (leader, 32 LSB-first bits, stop,
//          gap to a fixed frame period). Define NEC_TX_CARRIER_EN to modulate
//          marks with the carrier instead of emitting the raw envelope.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nec_ir_tx
    import nec_tx_pkg::*;
#(
    parameter int TICK_CLKS    = 28125,
    parameter int FRAME_UNITS  = 192,
    parameter int CARRIER_CLKS = 1315
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    nec_ir_tx_if.slave bus,
    output logic       ir_out
);

    localparam int TW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
    localparam logic [TW-1:0] c_tick_last  = TW'(TICK_CLKS - 1);
    localparam logic [7:0]    c_frame_last = 8'(FRAME_UNITS - 1);
    localparam logic [4:0]    c_bit_last   = 5'(NUM_BITS - 1);

    localparam logic [2:0] c_st_idle       = ST_IDLE;
    localparam logic [2:0] c_st_lead_mark  = ST_LEAD_MARK;
    localparam logic [2:0] c_st_lead_space = ST_LEAD_SPACE;
    localparam logic [2:0] c_st_bit_mark   = ST_BIT_MARK;
    localparam logic [2:0] c_st_bit_space  = ST_BIT_SPACE;
    localparam logic [2:0] c_st_stop_mark  = ST_STOP_MARK;
    localparam logic [2:0] c_st_gap        = ST_GAP;

    if (TICK_CLKS < 1 || FRAME_UNITS < 154 || FRAME_UNITS > 255 || CARRIER_CLKS < 3) begin : g_param_check
        $error("nec_ir_tx: parameter out of range");
    end

    logic [2:0]          r_state;
    logic [TW-1:0]       r_tick;
    logic [4:0]          r_unit;
    logic [7:0]          r_frame;
    logic [NUM_BITS-1:0] r_shift;
    logic [4:0]          r_bit;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    logic [2:0]          w_state_nxt;
    logic [TW-1:0]       w_tick_nxt;
    logic [4:0]          w_unit_nxt;
    logic [7:0]          w_frame_nxt;
    logic [NUM_BITS-1:0] w_shift_nxt;
    logic [4:0]          w_bit_nxt;
    logic [4:0]          w_dur;
    logic                w_tick_wrap;
    logic                w_unit_last;
    logic                w_mark_nxt;

    always_comb begin
        w_tick_wrap = (r_tick == c_tick_last);
        case (r_state)
            c_st_lead_mark:  w_dur = 5'(LEAD_MARK_U);
            c_st_lead_space: w_dur = 5'(LEAD_SPACE_U);
            c_st_bit_mark:   w_dur = 5'(BIT_MARK_U);
            c_st_bit_space:  w_dur = r_shift[0] ? 5'(ONE_SPACE_U) : 5'(ZERO_SPACE_U);
            default:         w_dur = 5'(STOP_MARK_U);
        endcase
        w_unit_last = (r_unit == w_dur - 5'd1);

        w_state_nxt = r_state;
        w_tick_nxt  = w_tick_wrap ? '0 : r_tick + TW'(1);
        w_unit_nxt  = w_tick_wrap ? r_unit + 5'd1 : r_unit;
        w_frame_nxt = (w_tick_wrap && r_frame != 8'hFF) ? r_frame + 8'd1 : r_frame;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;

        case (r_state)
            c_st_idle: begin
                w_tick_nxt  = '0;
                w_unit_nxt  = '0;
                w_frame_nxt = '0;
                if (bus.valid) begin
                    w_state_nxt = c_st_lead_mark;
                    w_shift_nxt = bus.data;
                    w_bit_nxt   = '0;
                end
            end
            c_st_gap: begin
                w_unit_nxt = '0;
                if (w_tick_wrap && r_frame == c_frame_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                if (w_tick_wrap && w_unit_last) begin
                    case (r_state)
                        c_st_lead_mark:  w_state_nxt = c_st_lead_space;
                        c_st_lead_space: w_state_nxt = c_st_bit_mark;
                        c_st_bit_mark:   w_state_nxt = c_st_bit_space;
                        c_st_bit_space: begin
                            if (r_bit == c_bit_last) begin
                                w_state_nxt = c_st_stop_mark;
                            end else begin
                                w_state_nxt = c_st_bit_mark;
                                w_bit_nxt   = r_bit + 5'd1;
                                w_shift_nxt = r_shift >> 1;
                            end
                        end
                        default:         w_state_nxt = c_st_gap;
                    endcase
                end
            end
        endcase

        // Every state entry restarts both the tick and per-state unit count
        if (w_state_nxt != r_state) begin
            w_tick_nxt = '0;
            w_unit_nxt = '0;
        end
        w_mark_nxt = is_mark(w_state_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_tick  <= '0;
            r_unit  <= '0;
            r_frame <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_unit  <= w_unit_nxt;
            r_frame <= w_frame_nxt;
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_ready <= (w_state_nxt == c_st_idle);
            r_busy  <= (w_state_nxt != c_st_idle);
            // Raised one edge early so it coincides with the last GAP cycle
            r_done  <= (w_state_nxt == c_st_gap) && (w_frame_nxt == c_frame_last)
                       && (w_tick_nxt == c_tick_last);
        end
    end

    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

`ifdef NEC_TX_CARRIER_EN
    logic w_carrier;

    ir_carrier_gen #(
        .CARRIER_CLKS (CARRIER_CLKS)
    ) u_carrier (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_mark    (w_mark_nxt),
        .o_carrier (w_carrier)
    );

    assign ir_out = w_carrier;
`else
    logic r_ir;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ir <= 1'b0;
        end else begin
            r_ir <= w_mark_nxt;
        end
    end

    assign ir_out = r_ir;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nec_ir_tx.sv
// ============================================================================
// Module : tb_nec_ir_tx
// Brief  : Self-checking bench for nec_ir_tx (short tick, optional carrier).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nec_ir_tx;

    localparam int TICK       = 4;
    localparam int FRAME_U    = 192;
    localparam int CAR        = 3;
    localparam int FRAME_CLKS = FRAME_U * TICK;

    logic clk;
    logic rst_n;
    logic ir_out;

    nec_ir_tx_if bus ();

    nec_ir_tx #(
        .TICK_CLKS    (TICK),
        .FRAME_UNITS  (FRAME_U),
        .CARRIER_CLKS (CAR)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .ir_out (ir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          active_u;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_wave [FRAME_CLKS];
    logic got_wave [FRAME_CLKS];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference waveform built from segment rules: (level, units) list expanded to clocks
    task automatic build_model(input logic [31:0] d);
        bit seg_l [$];
        int seg_u [$];
        int pos;
        seg_l.push_back(1'b1); seg_u.push_back(16);
        seg_l.push_back(1'b0); seg_u.push_back(8);
        for (int i = 0; i < 32; i++) begin
            seg_l.push_back(1'b1); seg_u.push_back(1);
            seg_l.push_back(1'b0); seg_u.push_back(d[i] ? 3 : 1);
        end
        seg_l.push_back(1'b1); seg_u.push_back(1);
        for (int k = 0; k < FRAME_CLKS; k++) exp_wave[k] = 1'b0;
        pos = 0;
        foreach (seg_u[s]) begin
            for (int j = 0; j < seg_u[s] * TICK; j++) begin
`ifdef NEC_TX_CARRIER_EN
                exp_wave[pos] = seg_l[s] && ((j % CAR) < (CAR / 3));
`else
                exp_wave[pos] = seg_l[s];
`endif
                pos++;
            end
        end
    endtask

    function automatic int space_start_units(input logic [31:0] d, input int bitn);
        int u;
        u = 24;
        for (int i = 0; i < bitn; i++) u += d[i] ? 4 : 2;
        return u + 1;
    endfunction

    // Called right after the handshake edge; samples every cycle of one frame period
    task automatic capture(input logic [31:0] d, input string tag, input bit drop_valid,
                           input logic [31:0] late_data);
        int n_done, done_at, status_bad, first_bad;
        n_done = 0; done_at = -1; status_bad = 0; first_bad = -1;
        build_model(d);
        for (int k = 0; k < FRAME_CLKS; k++) begin
            @(negedge clk);
            if (k == 0 && drop_valid) bus.valid = 1'b0;
            if (k == 200 && !drop_valid) bus.data = late_data;
            got_wave[k] = ir_out;
            if (bus.done) begin n_done++; done_at = k; end
            if (!bus.busy || bus.ready) status_bad++;
            if (got_wave[k] !== exp_wave[k] && first_bad < 0) first_bad = k;
        end
        check({tag, "_ir_first_bad_cycle"}, first_bad, -1);
        check({tag, "_done_cycle"}, done_at, FRAME_CLKS - 1);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_busy_ready_bad_cycles"}, status_bad, 0);
        @(negedge clk);
        check({tag, "_after_rdy_busy_done_ir"}, int'({bus.ready, bus.busy, bus.done, ir_out}), 4'b1000);
    endtask

    task automatic start_frame(input logic [31:0] d);
        @(negedge clk);
        check("ready_before_start", int'(bus.ready), 1);
        bus.valid = 1'b1;
        bus.data  = d;
        @(posedge clk);
    endtask

    function automatic int active_units();
        int last;
        last = -1;
        for (int k = 0; k < FRAME_CLKS; k++) if (got_wave[k]) last = k;
        return last / TICK + 1;
    endfunction

`ifndef NEC_TX_CARRIER_EN
    task automatic decode(output logic [31:0] w, output int bad);
        int p, m, s;
        p = 0; bad = 0; w = '0;
        m = 0; while (p < FRAME_CLKS && got_wave[p])  begin m++; p++; end
        s = 0; while (p < FRAME_CLKS && !got_wave[p]) begin s++; p++; end
        if (m != 16 * TICK || s != 8 * TICK) bad++;
        for (int i = 0; i < 32; i++) begin
            m = 0; while (p < FRAME_CLKS && got_wave[p])  begin m++; p++; end
            s = 0; while (p < FRAME_CLKS && !got_wave[p]) begin s++; p++; end
            if (m != TICK) bad++;
            w[i] = (s > 2 * TICK);
        end
    endtask
`endif

    vec_t tbl [5];

    initial begin
        logic [31:0] d;
        logic [31:0] dec;
        int          dbad;
        int          n_done;
        int          n_ir;
        int          rst_at;

        tbl[0] = '{32'hFD02_6B86, 121};
        tbl[1] = '{32'hFFFF_FFFF, 153};
        tbl[2] = '{32'h0000_0000, 89};
        tbl[3] = '{32'h0000_0001, 91};
        tbl[4] = '{32'h0000_FFFF, 121};

        rst_n = 1'b0; bus.valid = 1'b0; bus.data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdy_busy_done_ir", int'({bus.ready, bus.busy, bus.done, ir_out}), 4'b1000);
        rst_n = 1'b1;

        foreach (tbl[t]) begin
            start_frame(tbl[t].data);
            capture(tbl[t].data, $sformatf("tbl%0d", t), 1'b1, '0);
            check($sformatf("tbl%0d_active_units", t), active_units(), tbl[t].active_u);
            if (t == 0) begin
`ifdef NEC_TX_CARRIER_EN
                check("carrier_lead_first6", int'({got_wave[0], got_wave[1], got_wave[2],
                      got_wave[3], got_wave[4], got_wave[5]}), 6'b100100);
`else
                decode(dec, dbad);
                check("loopback_timing_bad", dbad, 0);
                check("loopback_word", int'(dec == 32'hFD02_6B86), 1);
                check("loopback_bits_27_16", int'(dec[27:16]), 12'hD02);
`endif
            end
        end

        for (int r = 0; r < 6; r++) begin
            d = $urandom;
            start_frame(d);
            capture(d, $sformatf("rnd%0d", r), 1'b1, '0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // valid held high; data changes mid-frame and a second frame must follow right after
        start_frame(32'hFD02_6B86);
        capture(32'hFD02_6B86, "busy1", 1'b0, 32'h0000_FFFF);
        @(posedge clk);
        capture(32'h0000_FFFF, "busy2", 1'b1, '0);

        // reset one cycle inside the space of bit 10
        start_frame(32'hFD02_6B86);
        rst_at = space_start_units(32'hFD02_6B86, 10) * TICK + 1;
        for (int k = 0; k <= rst_at; k++) begin
            @(negedge clk);
            if (k == 0) bus.valid = 1'b0;
        end
        check("pre_reset_in_space_ir", int'(ir_out), 0);
        check("pre_reset_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_rdy_busy_done_ir", int'({bus.ready, bus.busy, bus.done, ir_out}), 4'b1000);
        rst_n = 1'b1;
        n_done = 0; n_ir = 0;
        repeat (FRAME_CLKS + 32) begin
            @(negedge clk);
            if (bus.done) n_done++;
            if (ir_out) n_ir++;
        end
        check("midreset_done_pulses", n_done, 0);
        check("midreset_ir_high_cycles", n_ir, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
